// File: rtl/seg7_pkg.sv
// Shared constants and FSM state type for the seven-segment display path.
package seg7_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_MAX    = 9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a value source and the binary-to-BCD converter.
interface bin2bcd_seq_if #(
  parameter int IN_W = 16
);

  logic            start;
  logic [IN_W-1:0] bin_in;
  logic            busy;
  logic            done;
  logic            ovf;
  logic [3:0]      ones;
  logic [3:0]      tens;
  logic [3:0]      hundreds;
  logic [3:0]      thousands;

  modport master (
    output start, bin_in,
    input  busy, done, ovf, ones, tens, hundreds, thousands
  );

  modport slave (
    input  start, bin_in,
    output busy, done, ovf, ones, tens, hundreds, thousands
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: values of 5 or more get 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] nib,
  output logic [3:0] nib_adj
);

  // Correct one BCD nibble ahead of the shift
  always_comb begin
    nib_adj = nib;
    if (nib >= 4'd5) nib_adj = nib + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one shift per clock).
// Digit outputs update only on the completion cycle, so the downstream
// display never sees intermediate shift values.
// Optional build macro: BIN2BCD_HEX_FALLBACK_EN -- on overflow, show the raw
// low 16 bits as hex digits instead of saturating to 9999.
module bin2bcd_seq #(
  parameter int IN_W    = 16,
  parameter int BCD_MAX = seg7_pkg::BCD_MAX
) (
  input  logic          clk_100MHz,
  input  logic          reset,
  bin2bcd_seq_if.slave  bus
);

  import seg7_pkg::*;

  localparam int              SCR_W = DIGIT_W * NUM_DIGITS;
  localparam int              CNT_W = $clog2(IN_W) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_W - 1);
  localparam logic [IN_W-1:0] MAX_W = IN_W'(BCD_MAX);

  state_t             state;
  state_t             state_nx;
  logic [IN_W-1:0]    bin_q;
  logic [SCR_W-1:0]   scratch;
  logic [SCR_W-1:0]   scratch_adj;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_pend;
  logic               done_q;
  logic               ovf_q;
  logic [DIGIT_W-1:0] ones_q;
  logic [DIGIT_W-1:0] tens_q;
  logic [DIGIT_W-1:0] hundreds_q;
  logic [DIGIT_W-1:0] thousands_q;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib     (scratch[g*DIGIT_W +: DIGIT_W]),
      .nib_adj (scratch_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // State register
  always_ff @(posedge clk_100MHz) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: out-of-range inputs skip the shift phase entirely
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = (bus.bin_in > MAX_W) ? DONE : SHIFT;
      SHIFT:   if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture, correct-then-shift, and latch results on completion
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      bin_q       <= '0;
      scratch     <= '0;
      cnt         <= '0;
      ovf_pend    <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ones_q      <= '0;
      tens_q      <= '0;
      hundreds_q  <= '0;
      thousands_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin_q    <= bus.bin_in;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= (bus.bin_in > MAX_W);
          end
        end
        SHIFT: begin
          {scratch, bin_q} <= {scratch_adj, bin_q} << 1;
          cnt              <= cnt + 1'b1;
        end
        DONE: begin
          done_q <= 1'b1;
          ovf_q  <= ovf_pend;
          if (ovf_pend) begin
`ifdef BIN2BCD_HEX_FALLBACK_EN
            thousands_q <= bin_q[15:12];
            hundreds_q  <= bin_q[11:8];
            tens_q      <= bin_q[7:4];
            ones_q      <= bin_q[3:0];
`else
            thousands_q <= 4'd9;
            hundreds_q  <= 4'd9;
            tens_q      <= 4'd9;
            ones_q      <= 4'd9;
`endif
          end else begin
            thousands_q <= scratch[15:12];
            hundreds_q  <= scratch[11:8];
            tens_q      <= scratch[7:4];
            ones_q      <= scratch[3:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.ovf       = ovf_q;
  assign bus.ones      = ones_q;
  assign bus.tens      = tens_q;
  assign bus.hundreds  = hundreds_q;
  assign bus.thousands = thousands_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: conversions, overflow path, ignored start,
// mid-conversion reset, and back-to-back operation with start held high.
module tb_bin2bcd_seq;

`ifdef BIN2BCD_HEX_FALLBACK_EN
  localparam logic [15:0] OVF_DIGITS = 16'h2710;
`else
  localparam logic [15:0] OVF_DIGITS = 16'h9999;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.IN_W(16)) bif ();

  bin2bcd_seq #(.IN_W(16), .BCD_MAX(9999)) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .bus        (bif)
  );

  logic [15:0] digits;
  assign digits = {bif.thousands, bif.hundreds, bif.tens, bif.ones};

  int unsigned passed = 0;
  int unsigned total  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Start one conversion, wait for done, check latency/busy/result/pulse width
  task automatic run_conv(input string tag, input logic [15:0] v, input logic [15:0] exp_d,
                          input logic exp_ovf, input int exp_lat);
    int lat;
    int busy_n;
    bif.start  = 1'b1;
    bif.bin_in = v;
    tick();
    bif.start = 1'b0;
    lat = 0;
    busy_n = 0;
    while (!bif.done && lat < 40) begin
      if (bif.busy) busy_n++;
      tick();
      lat++;
    end
    chk({tag, "_lat"},    32'(lat),    32'(exp_lat));
    chk({tag, "_busy"},   32'(busy_n), 32'(exp_lat));
    chk({tag, "_digits"}, 32'(digits), 32'(exp_d));
    chk({tag, "_ovf"},    32'(bif.ovf), 32'(exp_ovf));
    tick();
    chk({tag, "_pulse"},  32'(bif.done), 32'd0);
    chk({tag, "_hold"},   32'(digits), 32'(exp_d));
  endtask

  initial begin
    int lat;
    int extra;
    int glitch;
    int hold_bad;
    int nd;
    int t [3];
    bit seen;

    reset      = 1'b1;
    bif.start  = 1'b0;
    bif.bin_in = '0;
    repeat (3) tick();
    chk("rst_busy",   32'(bif.busy), 32'd0);
    chk("rst_done",   32'(bif.done), 32'd0);
    chk("rst_ovf",    32'(bif.ovf),  32'd0);
    chk("rst_digits", 32'(digits),   32'd0);
    reset = 1'b0;
    tick();

    run_conv("c1234",  16'd1234,  16'h1234, 1'b0, 17);
    run_conv("c0",     16'd0,     16'h0000, 1'b0, 17);
    run_conv("c9999",  16'd9999,  16'h9999, 1'b0, 17);
    run_conv("c1000",  16'd1000,  16'h1000, 1'b0, 17);
    run_conv("c10000", 16'd10000, OVF_DIGITS, 1'b1, 1);

    // start during a conversion must be ignored
    bif.start  = 1'b1;
    bif.bin_in = 16'd4321;
    tick();
    bif.start = 1'b0;
    lat = 0;
    repeat (4) begin tick(); lat++; end
    bif.start  = 1'b1;
    bif.bin_in = 16'd5555;
    tick();
    lat++;
    bif.start = 1'b0;
    while (!bif.done && lat < 40) begin tick(); lat++; end
    chk("ign_lat",    32'(lat),     32'd17);
    chk("ign_digits", 32'(digits),  32'h4321);
    chk("ign_ovf",    32'(bif.ovf), 32'd0);
    extra = 0;
    repeat (25) begin tick(); if (bif.done) extra++; end
    chk("ign_extra_done", 32'(extra),  32'd0);
    chk("ign_hold",       32'(digits), 32'h4321);

    // reset mid-conversion aborts without a done pulse
    bif.start  = 1'b1;
    bif.bin_in = 16'd8765;
    tick();
    bif.start = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    chk("abort_busy",   32'(bif.busy), 32'd0);
    chk("abort_done",   32'(bif.done), 32'd0);
    chk("abort_digits", 32'(digits),   32'd0);
    reset = 1'b0;
    extra = 0;
    repeat (25) begin tick(); if (bif.done) extra++; end
    chk("abort_no_done", 32'(extra),  32'd0);
    chk("abort_zero",    32'(digits), 32'd0);

    run_conv("c42", 16'd42, 16'h0042, 1'b0, 17);

    // start held high: back-to-back conversions every 18 cycles
    bif.start  = 1'b1;
    bif.bin_in = 16'd57;
    tick();
    nd = 0;
    seen = 1'b0;
    glitch = 0;
    hold_bad = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bif.done) begin
        if (nd < 3) t[nd] = i;
        nd++;
        seen = 1'b1;
      end
      if (seen && digits !== 16'h0057) glitch++;
      if (!seen && digits !== 16'h0042) hold_bad++;
    end
    bif.start = 1'b0;
    chk("b2b_count",  32'(nd),       32'd3);
    chk("b2b_first",  32'(t[0]),     32'd17);
    chk("b2b_gap1",   32'(t[1]-t[0]), 32'd18);
    chk("b2b_gap2",   32'(t[2]-t[1]), 32'd18);
    chk("b2b_glitch", 32'(glitch),   32'd0);
    chk("b2b_prehold", 32'(hold_bad), 32'd0);

    lat = 0;
    while (bif.busy && lat < 40) begin tick(); lat++; end
    chk("drain_idle", 32'(bif.busy), 32'd0);
    tick();
    chk("drain_digits", 32'(digits), 32'h0057);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
